f18a_bus_bridge: RTL and testbench

- Upstream stage of the F18A VDP wrapper: converts single-cycle host (Apple II slot) VDP port requests into correctly timed 9918A CPU-port cycles (mode, csw_n, csr_n, cd).
- Requests are queued in order in a small FIFO and issued by a strobe sequencer; read data is captured from the VDP and returned to the host.
- Also conditions the VDP interrupt for the host.

---
 rtl/f18a_bus_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_f18a_bus_bridge.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f18a_bus_bridge.sv
// f18a_bus_bridge: queues single-cycle host VDP port requests and replays them as timed 9918A CPU-port cycles.
// Define F18A_BRIDGE_IRQ_LATCH_EN to make irq_o sticky until the next status (mode 1) read.
module f18a_bus_bridge #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned STROBE_CYCLES = 3,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic       clk_logic_i,
    input  logic       reset_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_write_i,
    input  logic       req_mode_i,
    input  logic [7:0] req_data_i,
    output logic       rd_valid_o,
    output logic [7:0] rd_data_o,
    output logic       vdp_mode_o,
    output logic       vdp_csw_n_o,
    output logic       vdp_csr_n_o,
    output logic [7:0] vdp_cd_o,
    input  logic [7:0] vdp_cd_i,
    input  logic       vdp_int_n_i,
    output logic       irq_o,
    output logic       busy_o
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TMR_W  = 4;

    typedef struct packed {
        logic              write;
        logic              mode;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_GAP
    } state_t;

    req_t              mem_q [FIFO_DEPTH];
    req_t              head;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              push, pop;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] cd_q, cd_d;
    logic              csw_n_q, csw_n_d;
    logic              csr_n_q, csr_n_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              irq_q, irq_d;
`ifdef F18A_BRIDGE_IRQ_LATCH_EN
    logic              int_n_q, int_n_d;
`endif

    assign push = req_valid_i && ready_q;
    assign head = mem_q[rd_ptr_q];

    // Queue storage; flushing is done through the pointers, so the array needs no reset.
    always_ff @(posedge clk_logic_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_t'({req_write_i, req_mode_i, req_data_i});
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CNT_W'(FIFO_DEPTH));
        busy_d  = (count_d != CNT_W'(0)) || (state_d != S_IDLE);
    end

    // Strobe sequencer: IDLE pops, SETUP settles mode/cd, STROBE drives one strobe, GAP rests the bus.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        mode_d     = mode_q;
        cd_d       = cd_q;
        csw_n_d    = 1'b1;
        csr_n_d    = 1'b1;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != CNT_W'(0)) begin
                    pop     = 1'b1;
                    write_d = head.write;
                    mode_d  = head.mode;
                    cd_d    = head.data;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = TMR_W'(STROBE_CYCLES - 1);
                csw_n_d = !write_q;
                csr_n_d = write_q;
            end
            S_STROBE: begin
                if (cnt_q == TMR_W'(0)) begin
                    state_d = S_GAP;
                    cnt_d   = TMR_W'(GAP_CYCLES - 1);
                    if (!write_q) begin
                        rd_data_d  = vdp_cd_i;
                        rd_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q - TMR_W'(1);
                    csw_n_d = !write_q;
                    csr_n_d = write_q;
                end
            end
            S_GAP: begin
                if (cnt_q == TMR_W'(0)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef F18A_BRIDGE_IRQ_LATCH_EN
    // Sticky interrupt: a falling edge sets it, entering a status-read strobe clears it; set wins.
    always_comb begin
        int_n_d = vdp_int_n_i;
        irq_d   = irq_q;
        if ((state_q == S_SETUP) && !write_q && mode_q) begin
            irq_d = 1'b0;
        end
        if (int_n_q && !vdp_int_n_i) begin
            irq_d = 1'b1;
        end
    end
`else
    always_comb begin
        irq_d = !vdp_int_n_i;
    end
`endif

    always_ff @(posedge clk_logic_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            mode_q     <= 1'b0;
            cd_q       <= '0;
            csw_n_q    <= 1'b1;
            csr_n_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            irq_q      <= 1'b0;
`ifdef F18A_BRIDGE_IRQ_LATCH_EN
            int_n_q    <= 1'b1;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            mode_q     <= mode_d;
            cd_q       <= cd_d;
            csw_n_q    <= csw_n_d;
            csr_n_q    <= csr_n_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            irq_q      <= irq_d;
`ifdef F18A_BRIDGE_IRQ_LATCH_EN
            int_n_q    <= int_n_d;
`endif
        end
    end

    assign req_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign vdp_mode_o  = mode_q;
    assign vdp_csw_n_o = csw_n_q;
    assign vdp_csr_n_o = csr_n_q;
    assign vdp_cd_o    = cd_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_f18a_bus_bridge.sv
// Bench for f18a_bus_bridge: directed steps plus random traffic checked against a transaction-timing model.
module tb_f18a_bus_bridge;

    localparam int DEPTH = 4;
    localparam int S     = 3;
    localparam int G     = 2;
    localparam int PER   = 2 + S + G;

    logic       clk_logic_i = 1'b0;
    logic       reset_i     = 1'b1;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic       req_write_i = 1'b0;
    logic       req_mode_i  = 1'b0;
    logic [7:0] req_data_i  = 8'h00;
    logic       rd_valid_o;
    logic [7:0] rd_data_o;
    logic       vdp_mode_o;
    logic       vdp_csw_n_o;
    logic       vdp_csr_n_o;
    logic [7:0] vdp_cd_o;
    logic [7:0] vdp_cd_i;
    logic       vdp_int_n_i = 1'b1;
    logic       irq_o;
    logic       busy_o;

    f18a_bus_bridge #(
        .FIFO_DEPTH   (DEPTH),
        .STROBE_CYCLES(S),
        .GAP_CYCLES   (G)
    ) dut (
        .clk_logic_i(clk_logic_i),
        .reset_i    (reset_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_write_i(req_write_i),
        .req_mode_i (req_mode_i),
        .req_data_i (req_data_i),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o),
        .vdp_mode_o (vdp_mode_o),
        .vdp_csw_n_o(vdp_csw_n_o),
        .vdp_csr_n_o(vdp_csr_n_o),
        .vdp_cd_o   (vdp_cd_o),
        .vdp_cd_i   (vdp_cd_i),
        .vdp_int_n_i(vdp_int_n_i),
        .irq_o      (irq_o),
        .busy_o     (busy_o)
    );

    always #5 clk_logic_i = ~clk_logic_i;

    // Accepted transaction with its predicted strobe start cycle and expected read data.
    typedef struct {
        int         acc;
        int         start;
        bit         w;
        bit         m;
        logic [7:0] d;
        logic [7:0] rd;
    } tx_t;

    tx_t        txq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_start = -100;
    logic [7:0] mlast = 8'h00;

    // Fake VDP: reads return the last data-port write XOR 0x5C.
    logic [7:0] vdp_last = 8'h00;
    logic       prev_csw = 1'b1;
    assign vdp_cd_i = vdp_last ^ 8'h5C;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_logic_i) cyc <= cyc + 1;

    int         quiet = 0;
    int         occ;
    bit         act;
    logic       e_csw, e_csr, e_rv, e_mode, on_bus, bus_w;
    logic [7:0] e_cd, e_rd;
    logic [7:0] last_rd = 8'h00;
    tx_t        mt;

    // Cycle-level expectations derived from the predicted start cycle of every queued transaction.
    always @(negedge clk_logic_i) begin
        if (reset_i) begin
            txq.delete();
            quiet   = 2;
            last_rd = 8'h00;
        end else if (quiet > 0) begin
            quiet--;
        end else begin
            while (txq.size() > 0 && txq[0].start + S + G - 1 < cyc) void'(txq.pop_front());
            occ = 0; act = 0; e_csw = 1; e_csr = 1; e_rv = 0; on_bus = 0;
            e_mode = 0; e_cd = 0; e_rd = 0; bus_w = 0;
            foreach (txq[i]) begin
                mt = txq[i];
                if (mt.acc < cyc && mt.start - 2 >= cyc) occ++;
                if (mt.start - 2 < cyc && cyc <= mt.start + S + G - 1) act = 1;
                if (mt.start <= cyc && cyc <= mt.start + S - 1) begin
                    if (mt.w) e_csw = 0; else e_csr = 0;
                end
                if (mt.start - 1 <= cyc && cyc <= mt.start + S - 1) begin
                    on_bus = 1; e_mode = mt.m; e_cd = mt.d; bus_w = mt.w;
                end
                if (!mt.w && cyc == mt.start + S) begin
                    e_rv = 1; e_rd = mt.rd;
                end
            end
            chk("ready", req_ready_o, occ < DEPTH);
            chk("busy", busy_o, (occ != 0) || act);
            chk("csw_n", vdp_csw_n_o, e_csw);
            chk("csr_n", vdp_csr_n_o, e_csr);
            chk("rd_valid", rd_valid_o, e_rv);
            if (e_rv) last_rd = e_rd;
            chk("rd_data", rd_data_o, last_rd);
            if (on_bus) begin
                chk("mode", vdp_mode_o, e_mode);
                if (bus_w) chk("cd", vdp_cd_o, e_cd);
            end
        end
        if (!reset_i && prev_csw == 1'b0 && vdp_csw_n_o == 1'b1 && vdp_mode_o == 1'b0)
            vdp_last = vdp_cd_o;
        prev_csw = vdp_csw_n_o;
    end

    task automatic push(input bit w, input bit m, input logic [7:0] d);
        tx_t t;
        int  n;
        n = 0;
        req_valid_i = 1'b1; req_write_i = w; req_mode_i = m; req_data_i = d;
        while (req_ready_o !== 1'b1 && n < 200) begin
            @(negedge clk_logic_i);
            n++;
        end
        chk("push_bound", 32'(n >= 200), 0);
        t.acc   = cyc;
        t.start = (cyc + 3 > last_start + PER) ? cyc + 3 : last_start + PER;
        last_start = t.start;
        t.w = w; t.m = m; t.d = d;
        if (w && !m) mlast = d;
        t.rd = mlast ^ 8'h5C;
        txq.push_back(t);
        @(negedge clk_logic_i);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy_o !== 1'b0 || req_ready_o !== 1'b1) && n < 1000) begin
            @(negedge clk_logic_i);
            n++;
        end
        chk(tag, 32'(n >= 1000), 0);
    endtask

    bit         rw, rm;
    logic [7:0] rdat;
    int         nw;

    initial begin
        // Reset state
        repeat (3) @(negedge clk_logic_i);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_csw", vdp_csw_n_o, 1);
        chk("rst_csr", vdp_csr_n_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_rdv", rd_valid_o, 0);
        chk("rst_rdata", rd_data_o, 8'h00);
        chk("rst_mode", vdp_mode_o, 0);
        chk("rst_cd", vdp_cd_o, 8'h00);
        chk("rst_irq", irq_o, 0);
        reset_i = 1'b0;
        @(negedge clk_logic_i);
        chk("ready_after_rst", req_ready_o, 1);
        repeat (2) @(negedge clk_logic_i);

        // Single write: csw_n low for cycles 3..5 after the accept cycle
        push(1'b1, 1'b0, 8'h5A);
        for (int k = 1; k <= 6; k++) begin
            chk("w5a_csw", vdp_csw_n_o, (k >= 3 && k <= 5) ? 1'b0 : 1'b1);
            chk("w5a_csr", vdp_csr_n_o, 1);
            if (k >= 2) begin
                chk("w5a_cd", vdp_cd_o, 8'h5A);
                chk("w5a_mode", vdp_mode_o, 0);
            end
            @(negedge clk_logic_i);
        end
        wait_idle("idle_w5a");

        // Back-to-back burst of 5 writes
        for (int v = 1; v <= 5; v++) push(1'b1, 1'b0, 8'(v));
        wait_idle("idle_burst");

        // Write, register write, then a read returning 0xC3
        push(1'b1, 1'b0, 8'h9F);
        push(1'b1, 1'b1, 8'h80);
        push(1'b0, 1'b0, 8'h00);
        wait_idle("idle_rd");
        chk("rd_c3", rd_data_o, 8'hC3);
        chk("cd_hold", vdp_cd_o, 8'h00);

        // Reset during the strobe of a read
        push(1'b0, 1'b0, 8'h00);
        nw = 0;
        while (vdp_csr_n_o !== 1'b0 && nw < 50) begin
            @(negedge clk_logic_i);
            nw++;
        end
        chk("csr_wait_bound", 32'(nw >= 50), 0);
        reset_i = 1'b1;
        @(negedge clk_logic_i);
        chk("abort_csr", vdp_csr_n_o, 1);
        chk("abort_csw", vdp_csw_n_o, 1);
        chk("abort_busy", busy_o, 0);
        chk("abort_rdv", rd_valid_o, 0);
        @(negedge clk_logic_i);
        chk("abort_ready", req_ready_o, 0);
        reset_i    = 1'b0;
        last_start = -100;
        @(negedge clk_logic_i);
        chk("abort_ready_back", req_ready_o, 1);
        for (int k = 0; k < 6; k++) begin
            chk("abort_no_rdv", rd_valid_o, 0);
            @(negedge clk_logic_i);
        end

        // Interrupt conditioning
        chk("irq_idle", irq_o, 0);
        vdp_int_n_i = 1'b0;
        @(negedge clk_logic_i);
        chk("irq_set", irq_o, 1);
        vdp_int_n_i = 1'b1;
        @(negedge clk_logic_i);
`ifdef F18A_BRIDGE_IRQ_LATCH_EN
        chk("irq_sticky", irq_o, 1);
        repeat (4) @(negedge clk_logic_i);
        chk("irq_sticky_late", irq_o, 1);
        push(1'b0, 1'b1, 8'h00);
        wait_idle("idle_status");
        chk("irq_cleared", irq_o, 0);
`else
        chk("irq_follow", irq_o, 0);
        @(negedge clk_logic_i);
        chk("irq_stay_low", irq_o, 0);
`endif

        // Random traffic with idle gaps
        for (int i = 0; i < 40; i++) begin
            rw   = 1'($urandom_range(0, 1));
            rm   = 1'($urandom_range(0, 1));
            rdat = 8'($urandom);
            push(rw, rm, rdat);
            repeat ($urandom_range(0, 8)) @(negedge clk_logic_i);
        end
        wait_idle("idle_rand");

        // Back-to-back random traffic to exercise full FIFO and pointer wrap
        for (int i = 0; i < 20; i++) begin
            rw   = 1'($urandom_range(0, 1));
            rm   = 1'($urandom_range(0, 1));
            rdat = 8'($urandom);
            push(rw, rm, rdat);
        end
        wait_idle("idle_wrap");
        repeat (3) @(negedge clk_logic_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
